// File: rtl/cell_editor.sv
// cell_editor: debounced button cursor over a cell grid with read-modify-write cell toggle
// Ports: clk_in/rst_n_in (async active-low); btn_in {c,u,l,r,d} raw buttons;
// edit_en_in enables edits; data_r_in line read back one cycle after addr_r_out;
// addr_w_out/data_w_out/we_out single-cycle line write; cursor_x_out/cursor_y_out
// cursor position for overlay; busy_out high while a toggle is in flight.
module cell_editor #(
  parameter int LINE_WIDTH      = 8,
  parameter int ADDR_SIZE       = 3,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [4:0]                    btn_in,
  input  logic                          edit_en_in,
  input  logic [LINE_WIDTH-1:0]         data_r_in,
  output logic [ADDR_SIZE-1:0]          addr_r_out,
  output logic [ADDR_SIZE-1:0]          addr_w_out,
  output logic [LINE_WIDTH-1:0]         data_w_out,
  output logic                          we_out,
  output logic [$clog2(LINE_WIDTH)-1:0] cursor_x_out,
  output logic [ADDR_SIZE-1:0]          cursor_y_out,
  output logic                          busy_out
);
  localparam int XW = $clog2(LINE_WIDTH);
  localparam int CW = DEBOUNCE_CYCLES > 1 ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [XW-1:0] X_MAX = XW'(LINE_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, READ, MODIFY, WRITE} state_t;
  state_t state;
  logic [4:0] sync1, sync2, stable, press, act;
  logic [CW-1:0] cnt [5];
  logic [XW-1:0] x_lat;
  logic [ADDR_SIZE-1:0] y_lat;
  // bit order {c,u,l,r,d}; presses outside IDLE or while disabled are dropped
  assign act = press & {5{edit_en_in && state == IDLE}};
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
      for (int i = 0; i < 5; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) cnt[i] <= '0;
        else if (cnt[i] == CNT_MAX) begin
          cnt[i]    <= '0;
          stable[i] <= ~stable[i];
          press[i]  <= ~stable[i];
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= IDLE;
      cursor_x_out <= '0;
      cursor_y_out <= '0;
      x_lat        <= '0;
      y_lat        <= '0;
      addr_r_out   <= '0;
      addr_w_out   <= '0;
      data_w_out   <= '0;
      we_out       <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      if (act[2] && !act[1]) cursor_x_out <= cursor_x_out == '0 ? X_MAX : cursor_x_out - 1'b1;
      else if (act[1] && !act[2]) cursor_x_out <= cursor_x_out == X_MAX ? '0 : cursor_x_out + 1'b1;
      if (act[3] && !act[0]) cursor_y_out <= cursor_y_out - 1'b1;
      else if (act[0] && !act[3]) cursor_y_out <= cursor_y_out + 1'b1;
      case (state)
        IDLE: if (act[4]) begin
          x_lat      <= cursor_x_out;
          y_lat      <= cursor_y_out;
          addr_r_out <= cursor_y_out;
          busy_out   <= 1'b1;
          state      <= READ;
        end
        READ: state <= MODIFY;
        MODIFY: begin
          data_w_out <= data_r_in ^ (LINE_WIDTH'(1) << x_lat);
          addr_w_out <= y_lat;
          we_out     <= 1'b1;
          state      <= WRITE;
        end
        WRITE: begin
          we_out   <= 1'b0;
          busy_out <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cell_editor.sv
// tb_cell_editor: directed self-checking bench for cell_editor
module tb_cell_editor;
  localparam logic [4:0] BC = 5'b10000, BU = 5'b01000, BL = 5'b00100, BR = 5'b00010, BD = 5'b00001;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [4:0] btn_in = '0;
  logic edit_en_in = 1'b1;
  logic [7:0] data_r_in = '0;
  logic [2:0] addr_r_out, addr_w_out, cursor_x_out, cursor_y_out;
  logic [7:0] data_w_out;
  logic we_out, busy_out;
  int vectors = 0;
  int miscompares = 0;
  int we_cnt = 0;
  logic [2:0] we_addr = '0;
  logic [7:0] we_data = '0;
  cell_editor #(.LINE_WIDTH(8), .ADDR_SIZE(3), .DEBOUNCE_CYCLES(4)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .btn_in(btn_in), .edit_en_in(edit_en_in),
    .data_r_in(data_r_in), .addr_r_out(addr_r_out), .addr_w_out(addr_w_out),
    .data_w_out(data_w_out), .we_out(we_out), .cursor_x_out(cursor_x_out),
    .cursor_y_out(cursor_y_out), .busy_out(busy_out)
  );
  always #5 clk_in = ~clk_in;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_in);
    #1;
    if (we_out) begin
      we_cnt++;
      we_addr = addr_w_out;
      we_data = data_w_out;
    end
  endtask
  task automatic run(int n);
    repeat (n) tick();
  endtask
  task automatic press(logic [4:0] m);
    btn_in = m;
    run(12);
    btn_in = '0;
    run(12);
  endtask
  task automatic do_reset();
    rst_n_in = 1'b0;
    run(2);
    rst_n_in = 1'b1;
    run(2);
  endtask
  initial begin
    run(3);
    check("rst_x", cursor_x_out, 0);
    check("rst_y", cursor_y_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_we", we_out, 0);
    check("rst_addr_r", addr_r_out, 0);
    check("rst_addr_w", addr_w_out, 0);
    check("rst_data_w", data_w_out, 0);
    rst_n_in = 1'b1;
    run(5);
    check("post_rst_x", cursor_x_out, 0);
    for (int i = 0; i < 10; i++) begin
      btn_in = btn_in ^ BR;
      run(2);
    end
    check("bounce_x", cursor_x_out, 0);
    btn_in = BR;
    run(10);
    check("hold_x", cursor_x_out, 1);
    btn_in = '0;
    run(12);
    check("release_x", cursor_x_out, 1);
    do_reset();
    press(BL);
    check("wrap_l_x", cursor_x_out, 7);
    check("wrap_l_y", cursor_y_out, 0);
    press(BU);
    check("wrap_u_x", cursor_x_out, 7);
    check("wrap_u_y", cursor_y_out, 7);
    press(BR);
    check("wrap_r_x", cursor_x_out, 0);
    check("wrap_r_y", cursor_y_out, 7);
    do_reset();
    repeat (3) press(BR);
    repeat (3) press(BU);
    check("nav_x", cursor_x_out, 3);
    check("nav_y", cursor_y_out, 5);
    data_r_in = 8'h00;
    we_cnt = 0;
    press(BC);
    check("tog1_addr_r", addr_r_out, 5);
    check("tog1_we_cnt", we_cnt, 1);
    check("tog1_addr_w", we_addr, 5);
    check("tog1_data_w", we_data, 8'h08);
    check("tog1_busy", busy_out, 0);
    data_r_in = 8'h08;
    we_cnt = 0;
    press(BC);
    check("tog2_we_cnt", we_cnt, 1);
    check("tog2_data_w", we_data, 8'h00);
    edit_en_in = 1'b0;
    we_cnt = 0;
    press(BC | BD);
    check("gate_we_cnt", we_cnt, 0);
    check("gate_x", cursor_x_out, 3);
    check("gate_y", cursor_y_out, 5);
    edit_en_in = 1'b1;
    data_r_in = 8'hF0;
    we_cnt = 0;
    btn_in = BC;
    run(2);
    btn_in = BC | BR;
    run(12);
    btn_in = '0;
    run(14);
    check("busy_we_cnt", we_cnt, 1);
    check("busy_data_w", we_data, 8'hF8);
    check("busy_drop_x", cursor_x_out, 3);
    press(BL);
    repeat (4) press(BU);
    check("sim_nav_x", cursor_x_out, 2);
    check("sim_nav_y", cursor_y_out, 1);
    data_r_in = 8'h00;
    we_cnt = 0;
    press(BC | BL | BR);
    check("sim_we_cnt", we_cnt, 1);
    check("sim_addr_w", we_addr, 1);
    check("sim_data_w", we_data, 8'h04);
    check("sim_x", cursor_x_out, 2);
    check("sim_y", cursor_y_out, 1);
    we_cnt = 0;
    btn_in = BC;
    for (int k = 0; k < 30 && !busy_out; k++) tick();
    check("mid_busy", busy_out, 1);
    tick();
    #2 rst_n_in = 1'b0;
    #1;
    check("mid_rst_we", we_out, 0);
    check("mid_rst_busy", busy_out, 0);
    check("mid_rst_data_w", data_w_out, 0);
    check("mid_rst_addr_w", addr_w_out, 0);
    check("mid_rst_addr_r", addr_r_out, 0);
    check("mid_rst_x", cursor_x_out, 0);
    check("mid_rst_y", cursor_y_out, 0);
    btn_in = '0;
    run(5);
    rst_n_in = 1'b1;
    run(20);
    check("mid_rst_no_write", we_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
